// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and unified-memory signals around mem_port_arbiter.
// master is the arbiter's view; slave is the view of the requesters and the memory.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              i_read_cmd_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_cmd_ready;
   logic [31:0]       i_read_data;
   logic              i_read_data_valid;

   logic              d_read_cmd_valid;
   logic              d_write_cmd_valid;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_write_data;
   logic [3:0]        d_write_data_size;
   logic              d_cmd_ready;
   logic [31:0]       d_read_data;
   logic              d_read_data_valid;

   logic              mem_read_cmd_valid;
   logic              mem_write_cmd_valid;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_write_data;
   logic              mem_write_data_valid;
   logic [3:0]        mem_write_data_size;
   logic [31:0]       mem_read_data;
   logic              mem_read_data_valid;

   logic              err;

   modport master (
      input  i_read_cmd_valid, i_addr,
      input  d_read_cmd_valid, d_write_cmd_valid, d_addr, d_write_data, d_write_data_size,
      input  mem_read_data, mem_read_data_valid,
      output i_cmd_ready, i_read_data, i_read_data_valid,
      output d_cmd_ready, d_read_data, d_read_data_valid,
      output mem_read_cmd_valid, mem_write_cmd_valid, mem_addr, mem_write_data,
      output mem_write_data_valid, mem_write_data_size, err
   );

   modport slave (
      output i_read_cmd_valid, i_addr,
      output d_read_cmd_valid, d_write_cmd_valid, d_addr, d_write_data, d_write_data_size,
      output mem_read_data, mem_read_data_valid,
      input  i_cmd_ready, i_read_data, i_read_data_valid,
      input  d_cmd_ready, d_read_data, d_read_data_valid,
      input  mem_read_cmd_valid, mem_write_cmd_valid, mem_addr, mem_write_data,
      input  mem_write_data_valid, mem_write_data_size, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one mem_32 port between instruction fetch and data access: data has priority,
// fetch wins after MAX_I_WAIT lost rounds, one command outstanding, responses routed to the owner.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int MAX_I_WAIT = 4,
   parameter int RD_TIMEOUT = 255
) (
   input logic                clk,
   input logic                reset,
   mem_port_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

   localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
   localparam logic [3:0]  STARVE_LIMIT = 4'(MAX_I_WAIT);
   localparam logic [9:0]  TMO_LIMIT    = 10'(RD_TIMEOUT);

   state_t            r_state;
   state_t            w_next_state;
   logic              r_owner_d;
   logic              r_op_wr;
   logic [3:0]        r_starve_cnt;
   logic [9:0]        r_tmo_cnt;
   logic              r_err;
   logic              r_mem_rd_v;
   logic              r_mem_wr_v;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [3:0]        r_mem_size;
   logic [31:0]       r_i_data;
   logic [31:0]       r_d_data;

   logic        w_i_req;
   logic        w_d_req;
   logic        w_i_grant;
   logic        w_d_grant;
   logic        w_accept;
   logic        w_d_illegal;
   logic        w_in_wait;
   logic        w_timeout;
   logic        w_resp;
   logic        w_stray;
   logic [31:0] w_resp_data;

   assign w_i_req     = bus.i_read_cmd_valid;
   assign w_d_req     = bus.d_read_cmd_valid | bus.d_write_cmd_valid;
   assign w_d_illegal = bus.d_read_cmd_valid & bus.d_write_cmd_valid;
   assign w_accept    = w_i_grant | w_d_grant;
   assign w_in_wait   = (r_state == RD_WAIT);
   assign w_timeout   = w_in_wait && !bus.mem_read_data_valid && (r_tmo_cnt == TMO_LIMIT);
   assign w_resp      = w_in_wait && (bus.mem_read_data_valid || w_timeout);
   assign w_resp_data = bus.mem_read_data_valid ? bus.mem_read_data : TIMEOUT_DATA;
   assign w_stray     = bus.mem_read_data_valid && !w_in_wait;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         IDLE:    if (w_accept) w_next_state = ISSUE;
         ISSUE:   w_next_state = r_op_wr ? IDLE : RD_WAIT;
         RD_WAIT: if (w_resp) w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_i_grant = 1'b0;
      w_d_grant = 1'b0;
      if (r_state == IDLE) begin
         if (w_d_req && !(w_i_req && (r_starve_cnt == STARVE_LIMIT))) w_d_grant = 1'b1;
         else if (w_i_req)                                             w_i_grant = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_owner_d    <= 1'b0;
         r_op_wr      <= 1'b0;
         r_starve_cnt <= '0;
         r_tmo_cnt    <= '0;
         r_err        <= 1'b0;
         r_mem_rd_v   <= 1'b0;
         r_mem_wr_v   <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_size   <= '0;
         r_i_data     <= '0;
         r_d_data     <= '0;
      end else begin
         r_mem_rd_v <= 1'b0;
         r_mem_wr_v <= 1'b0;
         // A simultaneous read+write from data is treated as the write.
         if (w_d_grant) begin
            r_owner_d  <= 1'b1;
            r_op_wr    <= bus.d_write_cmd_valid;
            r_mem_rd_v <= !bus.d_write_cmd_valid;
            r_mem_wr_v <= bus.d_write_cmd_valid;
            r_mem_addr <= bus.d_addr;
            if (bus.d_write_cmd_valid) begin
               r_mem_wdata <= bus.d_write_data;
               r_mem_size  <= bus.d_write_data_size;
            end
         end else if (w_i_grant) begin
            r_owner_d  <= 1'b0;
            r_op_wr    <= 1'b0;
            r_mem_rd_v <= 1'b1;
            r_mem_addr <= bus.i_addr;
         end

         if (r_state == IDLE) begin
            if (w_i_grant || !w_i_req)     r_starve_cnt <= '0;
            else if (r_starve_cnt != 4'hF) r_starve_cnt <= r_starve_cnt + 4'd1;
         end

         if (r_state == ISSUE)                              r_tmo_cnt <= '0;
         else if (w_in_wait && !bus.mem_read_data_valid && !w_timeout) r_tmo_cnt <= r_tmo_cnt + 10'd1;

         if (w_resp) begin
            if (r_owner_d) r_d_data <= w_resp_data;
            else           r_i_data <= w_resp_data;
         end

         if (w_timeout || w_stray || (w_d_grant && w_d_illegal)) r_err <= 1'b1;
      end
   end

   assign bus.i_cmd_ready          = w_i_grant;
   assign bus.d_cmd_ready          = w_d_grant;
   assign bus.i_read_data_valid    = w_resp && !r_owner_d;
   assign bus.d_read_data_valid    = w_resp && r_owner_d;
   assign bus.i_read_data          = (w_resp && !r_owner_d) ? w_resp_data : r_i_data;
   assign bus.d_read_data          = (w_resp && r_owner_d) ? w_resp_data : r_d_data;
   assign bus.mem_read_cmd_valid   = r_mem_rd_v;
   assign bus.mem_write_cmd_valid  = r_mem_wr_v;
   assign bus.mem_write_data_valid = r_mem_wr_v;
   assign bus.mem_addr             = r_mem_addr;
   assign bus.mem_write_data       = r_mem_wdata;
   assign bus.mem_write_data_size  = r_mem_size;
   assign bus.err                  = r_err;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios, a transaction-level model compared every
// cycle, a simple mem_32 responder, and literal expectations pinning the model's timing.
module tb_mem_port_arbiter;
   localparam int          ADDR_W     = 32;
   localparam int          MAX_I_WAIT = 4;
   localparam int          RD_TIMEOUT = 8;
   localparam logic [31:0] TMO_DATA   = 32'hDEAD_BEEF;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .MAX_I_WAIT(MAX_I_WAIT), .RD_TIMEOUT(RD_TIMEOUT)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // model state
   int          m_free_at, m_cmd_cyc, m_silent, m_lost;
   bit          m_rd_pend, m_owner_d, m_cmd_wr, m_err, acc_i, acc_d;
   logic [31:0] m_cmd_addr, m_cmd_wdata, m_i_data, m_d_data;
   logic [3:0]  m_cmd_size;

   // memory responder
   bit          mute, stray_req, resp_pend;
   logic [31:0] resp_data;

   // observations of the DUT for the literal checks
   int          i_rdy_q[$], d_rdy_q[$], mem_rd_q[$], mem_wr_q[$], i_pulse_q[$], d_pulse_q[$];
   logic [31:0] i_pdata_q[$], d_pdata_q[$];
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_size;
   string       grant_log;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int idx);
      return (idx < q.size()) ? q[idx] : -1;
   endfunction

   function automatic logic [31:0] dget(input logic [31:0] q[$], input int idx);
      return (idx < q.size()) ? q[idx] : 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h10) ? 32'h1234_5678 : (a ^ 32'hC0DE_0000);
   endfunction

   task automatic clear_obs();
      i_rdy_q.delete(); d_rdy_q.delete(); mem_rd_q.delete(); mem_wr_q.delete();
      i_pulse_q.delete(); d_pulse_q.delete(); i_pdata_q.delete(); d_pdata_q.delete();
      grant_log = "";
   endtask

   task automatic observe();
      if (bus.i_cmd_ready) begin i_rdy_q.push_back(cyc); grant_log = {grant_log, "I"}; end
      if (bus.d_cmd_ready) begin d_rdy_q.push_back(cyc); grant_log = {grant_log, "D"}; end
      if (bus.mem_read_cmd_valid) mem_rd_q.push_back(cyc);
      if (bus.mem_write_cmd_valid) begin
         mem_wr_q.push_back(cyc);
         wr_addr = bus.mem_addr; wr_data = bus.mem_write_data; wr_size = bus.mem_write_data_size;
      end
      if (bus.i_read_data_valid) begin i_pulse_q.push_back(cyc); i_pdata_q.push_back(bus.i_read_data); end
      if (bus.d_read_data_valid) begin d_pulse_q.push_back(cyc); d_pdata_q.push_back(bus.d_read_data); end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_i_rdy"}, bus.i_cmd_ready, 0);
      check({tag, "_d_rdy"}, bus.d_cmd_ready, 0);
      check({tag, "_mem_rd"}, bus.mem_read_cmd_valid, 0);
      check({tag, "_mem_wr"}, bus.mem_write_cmd_valid, 0);
      check({tag, "_mem_wdv"}, bus.mem_write_data_valid, 0);
      check({tag, "_mem_addr"}, bus.mem_addr, 0);
      check({tag, "_mem_wdata"}, bus.mem_write_data, 0);
      check({tag, "_mem_size"}, 32'(bus.mem_write_data_size), 0);
      check({tag, "_i_dv"}, bus.i_read_data_valid, 0);
      check({tag, "_d_dv"}, bus.d_read_data_valid, 0);
      check({tag, "_i_data"}, bus.i_read_data, 0);
      check({tag, "_d_data"}, bus.d_read_data, 0);
      check({tag, "_err"}, bus.err, 0);
   endtask

   // Model: arbiter is free when no read is outstanding and any write has had its issue cycle;
   // each accepted command appears on mem exactly one cycle later; a read completes on the
   // first memory response after its issue cycle, or after RD_TIMEOUT silent cycles.
   task automatic model_step();
      bit          free, i_req, d_req, e_i_rdy, e_d_rdy, in_wait, e_pulse, e_cmd;
      logic [31:0] e_data;
      acc_i = 1'b0;
      acc_d = 1'b0;
      if (reset) begin
         check_all_zero("rst");
         m_free_at = 0; m_cmd_cyc = -10; m_silent = 0; m_lost = 0;
         m_rd_pend = 0; m_owner_d = 0; m_cmd_wr = 0; m_err = 0;
         m_i_data = '0; m_d_data = '0;
         return;
      end
      free    = !m_rd_pend && (cyc >= m_free_at);
      i_req   = bus.i_read_cmd_valid;
      d_req   = bus.d_read_cmd_valid || bus.d_write_cmd_valid;
      e_d_rdy = free && d_req && !(i_req && (m_lost >= MAX_I_WAIT));
      e_i_rdy = free && i_req && !e_d_rdy;
      in_wait = m_rd_pend && (cyc > m_cmd_cyc);
      e_pulse = in_wait && (bus.mem_read_data_valid || (m_silent == RD_TIMEOUT));
      e_data  = bus.mem_read_data_valid ? bus.mem_read_data : TMO_DATA;
      e_cmd   = (cyc == m_cmd_cyc);

      check("i_cmd_ready", bus.i_cmd_ready, e_i_rdy);
      check("d_cmd_ready", bus.d_cmd_ready, e_d_rdy);
      check("mem_read_cmd_valid", bus.mem_read_cmd_valid, e_cmd && !m_cmd_wr);
      check("mem_write_cmd_valid", bus.mem_write_cmd_valid, e_cmd && m_cmd_wr);
      check("mem_write_data_valid", bus.mem_write_data_valid, e_cmd && m_cmd_wr);
      if (e_cmd) check("mem_addr", bus.mem_addr, m_cmd_addr);
      if (e_cmd && m_cmd_wr) begin
         check("mem_write_data", bus.mem_write_data, m_cmd_wdata);
         check("mem_write_data_size", 32'(bus.mem_write_data_size), 32'(m_cmd_size));
      end
      check("i_read_data_valid", bus.i_read_data_valid, e_pulse && !m_owner_d);
      check("d_read_data_valid", bus.d_read_data_valid, e_pulse && m_owner_d);
      check("i_read_data", bus.i_read_data, (e_pulse && !m_owner_d) ? e_data : m_i_data);
      check("d_read_data", bus.d_read_data, (e_pulse && m_owner_d) ? e_data : m_d_data);
      check("err", bus.err, m_err);

      if (e_pulse) begin
         if (m_owner_d) m_d_data = e_data; else m_i_data = e_data;
         if (!bus.mem_read_data_valid) m_err = 1'b1;
         m_rd_pend = 1'b0;
         m_free_at = cyc + 1;
      end else if (in_wait) begin
         m_silent++;
      end
      if (bus.mem_read_data_valid && !in_wait) m_err = 1'b1;

      if (free) begin
         if (e_i_rdy || !i_req) m_lost = 0;
         else if (m_lost < 15)  m_lost++;
      end
      if (e_d_rdy || e_i_rdy) begin
         m_cmd_cyc = cyc + 1;
         m_owner_d = e_d_rdy;
         m_cmd_wr  = e_d_rdy && bus.d_write_cmd_valid;
         m_cmd_addr = e_d_rdy ? bus.d_addr : bus.i_addr;
         if (m_cmd_wr) begin
            m_cmd_wdata = bus.d_write_data;
            m_cmd_size  = bus.d_write_data_size;
            m_free_at   = cyc + 2;
         end else begin
            m_rd_pend = 1'b1;
            m_silent  = 0;
         end
         if (e_d_rdy && bus.d_read_cmd_valid && bus.d_write_cmd_valid) m_err = 1'b1;
      end
      acc_i = e_i_rdy;
      acc_d = e_d_rdy;
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
      observe();
      model_step();
      if (reset) begin
         resp_pend = 1'b0;
      end else begin
         if (bus.mem_read_cmd_valid && !mute) begin
            resp_pend = 1'b1;
            resp_data = mem_word(bus.mem_addr);
         end
         if (stray_req) begin
            resp_pend = 1'b1;
            resp_data = 32'h5757_0001;
         end
      end
      @(posedge clk);
      #1;
      bus.mem_read_data_valid = resp_pend;
      bus.mem_read_data       = resp_pend ? resp_data : 32'h0;
      resp_pend = 1'b0;
      stray_req = 1'b0;
   endtask

   // Requests drop once the model says they were accepted.
   task automatic run(input int n);
      repeat (n) begin
         tick();
         if (acc_i) bus.i_read_cmd_valid = 1'b0;
         if (acc_d) begin bus.d_read_cmd_valid = 1'b0; bus.d_write_cmd_valid = 1'b0; end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      run(2);
      reset = 1'b0;
      run(1);
   endtask

   initial begin
      int    t;
      string exp_s;
      reset = 1'b0;
      bus.i_read_cmd_valid = 0; bus.i_addr = '0;
      bus.d_read_cmd_valid = 0; bus.d_write_cmd_valid = 0; bus.d_addr = '0;
      bus.d_write_data = '0; bus.d_write_data_size = '0;
      bus.mem_read_data = '0; bus.mem_read_data_valid = 0;
      mute = 0; stray_req = 0; resp_pend = 0; resp_data = '0;
      #1 reset = 1'b1;
      run(3);
      reset = 1'b0;
      run(2);

      // 1: lone fetch read, two-cycle read latency
      clear_obs();
      bus.i_read_cmd_valid = 1; bus.i_addr = 32'h10;
      t = cyc + 1;
      run(6);
      check("t1_i_ready_cyc", qget(i_rdy_q, 0), t);
      check("t1_mem_rd_cyc", qget(mem_rd_q, 0), t + 1);
      check("t1_i_pulse_cyc", qget(i_pulse_q, 0), t + 2);
      check("t1_i_pulse_data", dget(i_pdata_q, 0), 32'h1234_5678);
      check("t1_d_pulses", d_pulse_q.size(), 0);

      // 2: data write, then a data read queued right behind it
      clear_obs();
      bus.d_write_cmd_valid = 1; bus.d_addr = 32'h100;
      bus.d_write_data = 32'hA5A5_A5A5; bus.d_write_data_size = 4'hF;
      t = cyc + 1;
      run(1);
      bus.d_read_cmd_valid = 1; bus.d_addr = 32'h200;
      run(6);
      check("t2_wr_count", mem_wr_q.size(), 1);
      check("t2_wr_cyc", qget(mem_wr_q, 0), t + 1);
      check("t2_wr_addr", wr_addr, 32'h100);
      check("t2_wr_data", wr_data, 32'hA5A5_A5A5);
      check("t2_wr_size", 32'(wr_size), 32'hF);
      check("t2_next_d_ready", qget(d_rdy_q, 1), t + 2);
      check("t2_d_pulse_data", dget(d_pdata_q, 0), 32'hC0DE_0200);
      check("t2_i_pulses", i_pulse_q.size(), 0);

      // 3: both requesters hold reads continuously
      clear_obs();
      bus.i_read_cmd_valid = 1; bus.i_addr = 32'h40;
      bus.d_read_cmd_valid = 1; bus.d_addr = 32'h80;
      for (int k = 0; k < 200 && grant_log.len() < 10; k++) tick();
      bus.i_read_cmd_valid = 0; bus.d_read_cmd_valid = 0;
      run(6);
      exp_s = "DDDDIDDDDI";
      for (int k = 0; k < 10; k++)
         check($sformatf("t3_grant%0d", k), 32'(grant_log[k]), 32'(exp_s[k]));
      check("t3_i_pulses", i_pulse_q.size(), 2);
      check("t3_d_pulses", d_pulse_q.size(), 8);
      check("t3_i_data", dget(i_pdata_q, 0), 32'hC0DE_0040);
      check("t3_d_data", dget(d_pdata_q, 0), 32'hC0DE_0080);

      // 4: memory never answers; timeout response, then normal service
      clear_obs();
      mute = 1;
      bus.i_read_cmd_valid = 1; bus.i_addr = 32'h20;
      t = cyc + 1;
      run(14);
      check("t4_i_pulse_cyc", qget(i_pulse_q, 0), t + 10);
      check("t4_i_pulse_data", dget(i_pdata_q, 0), TMO_DATA);
      check("t4_err", bus.err, 1);
      mute = 0;
      bus.d_read_cmd_valid = 1; bus.d_addr = 32'h300;
      t = cyc + 1;
      run(5);
      check("t4_d_ready_cyc", qget(d_rdy_q, 0), t);
      check("t4_d_pulse_data", dget(d_pdata_q, 0), 32'hC0DE_0300);

      // 5: reset while waiting for read data, then a stray memory response
      mute = 1;
      bus.i_read_cmd_valid = 1; bus.i_addr = 32'h30;
      run(3);
      clear_obs();
      reset = 1'b1;
      #1;
      check_all_zero("t5_async");
      run(2);
      reset = 1'b0;
      run(2);
      check("t5_err_before_stray", bus.err, 0);
      stray_req = 1;
      run(3);
      check("t5_i_pulses", i_pulse_q.size(), 0);
      check("t5_d_pulses", d_pulse_q.size(), 0);
      check("t5_err_after_stray", bus.err, 1);
      mute = 0;

      // 6: data read and write asserted together
      do_reset();
      clear_obs();
      bus.d_read_cmd_valid = 1; bus.d_write_cmd_valid = 1; bus.d_addr = 32'h400;
      bus.d_write_data = 32'h0BAD_F00D; bus.d_write_data_size = 4'h3;
      run(6);
      check("t6_wr_count", mem_wr_q.size(), 1);
      check("t6_rd_count", mem_rd_q.size(), 0);
      check("t6_wr_data", wr_data, 32'h0BAD_F00D);
      check("t6_wr_size", 32'(wr_size), 32'h3);
      check("t6_d_pulses", d_pulse_q.size(), 0);
      check("t6_err", bus.err, 1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one mem_32 port between the core's instruction-fetch requester (i_*) and data requester (d_*), so that instruction and data memories can be merged into a single unified memory instance.
- Sits between riscv and one mem_32 in the top level, and is clocked by the PLL output clock.
- Provides fixed data-port priority with a starvation guard for fetch.
- Serialises at most one outstanding command and routes each read response back to the requester that issued it.

Parameters:
- ADDR_W, 32, address width on all ports.
- MAX_I_WAIT, 4, number of consecutive lost arbitrations after which fetch wins over data (range 1..15).
- RD_TIMEOUT, 255, cycles in RD_WAIT without mem_read_data_valid before the timeout response fires (range 1..1023).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- i_read_cmd_valid  in  1  fetch read request; held until accepted.
- i_addr  in  ADDR_W  fetch address.
- i_cmd_ready  out  1  fetch request accepted this cycle.
- i_read_data  out  32  fetch read data.
- i_read_data_valid  out  1  one-cycle pulse; fetch data valid.
- d_read_cmd_valid  in  1  data read request; held until accepted.
- d_write_cmd_valid  in  1  data write request; held until accepted.
- d_addr  in  ADDR_W  data address.
- d_write_data  in  32  write data.
- d_write_data_size  in  4  byte-lane mask, passed through unchanged.
- d_cmd_ready  out  1  data request accepted this cycle.
- d_read_data  out  32  data read data.
- d_read_data_valid  out  1  one-cycle pulse; data read valid.
- mem_read_cmd_valid  out  1  to mem_32.
- mem_write_cmd_valid  out  1  to mem_32.
- mem_addr  out  ADDR_W  to mem_32.
- mem_write_data  out  32  to mem_32.
- mem_write_data_valid  out  1  to mem_32.
- mem_write_data_size  out  4  to mem_32.
- mem_read_data  in  32  from mem_32.
- mem_read_data_valid  in  1  from mem_32.
- err  out  1  sticky error flag; cleared only by reset.

Behaviour:

Reset:
- Asynchronous assertion of reset forces all registers to their reset state immediately:
  - FSM = IDLE, starve counter = 0, timeout counter = 0, err = 0.
  - All mem_* command outputs = 0; mem_addr, mem_write_data, mem_write_data_size = 0.
  - Both *_read_data_valid = 0; both *_read_data = 0.
- Reset mid-read: the in-flight response is dropped. A mem_read_data_valid arriving after reset deasserts, while in IDLE, is ignored.

FSM states: IDLE, ISSUE, RD_WAIT.
- IDLE:
  - Ready outputs are combinational and asserted only in IDLE.
  - If only one requester is valid, that requester gets ready.
  - If both are valid, d wins unless starve_cnt == MAX_I_WAIT, in which case i wins.
  - On acceptance (valid && ready), register the command into the mem_* outputs and go to ISSUE.
  - Record the owner (I or D) and the op (RD or WR).
- ISSUE (exactly 1 cycle):
  - mem_read_cmd_valid or mem_write_cmd_valid = 1. For writes, mem_write_data_valid = 1 as well.
  - Next state is RD_WAIT for a read, IDLE for a write. A write therefore occupies 2 cycles from accept to the next possible accept.
- RD_WAIT:
  - All mem_* command valids = 0.
  - On mem_read_data_valid: copy mem_read_data to the owner's *_read_data, pulse the owner's *_read_data_valid for 1 cycle, go to IDLE.
  - The non-owner's *_read_data_valid stays 0.
  - The timeout counter increments on every cycle with no mem_read_data_valid. When it reaches RD_TIMEOUT: set err = 1, return 32'hDEADBEEF with a valid pulse to the owner, go to IDLE.
  - The timeout counter is cleared on entering RD_WAIT.
- Read latency (accept to data-valid pulse) = mem latency + 1. With mem_32 returning data the cycle after its command, the data-valid pulse arrives 2 cycles after accept.
- A mem_read_data_valid outside RD_WAIT sets err = 1 and is otherwise ignored.

Starve counter (saturating, 4-bit):
- Increments when i is valid in IDLE and d is granted.
- Clears when i is granted, or when i is not valid in IDLE.

Illegal request:
- d_read_cmd_valid and d_write_cmd_valid both high: the write is performed and err = 1.

Requester rule:
- Requesters keep their address, data and size stable while valid && !ready. The arbiter does not sample them until acceptance.

Test Plan:
1. Reset, then i read at 0x0000_0010 alone, mem returns 0x1234_5678 one cycle after the command:
   - i_cmd_ready asserts in the same cycle as the request.
   - mem_read_cmd_valid is high at T+1.
   - i_read_data_valid pulses at T+2 with 0x1234_5678.
   - d_read_data_valid stays 0 throughout.
2. d write to 0x100 with data 0xA5A5_A5A5 and size 4'hF:
   - mem_write_cmd_valid and mem_write_data_valid are high for exactly 1 cycle with those values.
   - d_cmd_ready is next high 2 cycles after acceptance.
3. i and d both hold reads continuously, MAX_I_WAIT = 4:
   - Grant order is D,D,D,D,I,D,D,D,D,I...
   - Each response reaches only its owner.
4. Read issued and mem never returns valid, RD_TIMEOUT = 8:
   - 8 cycles after entering RD_WAIT, the owner receives 0xDEADBEEF with a valid pulse and err = 1.
   - The next request is accepted normally.
5. Assert reset while in RD_WAIT, then deliver mem_read_data_valid after reset is released:
   - All outputs are 0 immediately on reset.
   - No *_read_data_valid pulse occurs.
   - err = 1 from the stray valid.
6. d_read_cmd_valid and d_write_cmd_valid asserted together:
   - A single write is issued to mem.
   - err = 1.
   - No read response is produced.
